// File: rtl/vcve2_pkg.sv
// rtl/vcve2_pkg.sv - shared vector types and the beat-count helper for the VRF access unit
package vcve2_pkg;

    typedef enum logic [2:0] {
        LMUL_1    = 3'b000,
        LMUL_2    = 3'b001,
        LMUL_4    = 3'b010,
        LMUL_8    = 3'b011,
        LMUL_RSVD = 3'b100,
        LMUL_F8   = 3'b101,
        LMUL_F4   = 3'b110,
        LMUL_F2   = 3'b111
    } vlmul_e;

    typedef enum logic [2:0] {
        VRF_IDLE,
        VRF_AGU_WAIT,
        VRF_RD_REQ,
        VRF_RD_WAIT,
        VRF_EXEC,
        VRF_WR_REQ,
        VRF_WR_WAIT
    } vrf_state_t;

    // lmul is a signed exponent; fractional groups still need at least one beat
    function automatic int unsigned num_beats(int unsigned vlen, int unsigned width, vlmul_e lmul);
        logic [2:0]  l;
        logic [2:0]  neg;
        int unsigned base;
        int unsigned n;
        l    = lmul;
        neg  = 3'd0 - l;
        base = vlen / width;
        if (!l[2]) n = base << l[1:0];
        else       n = base >> neg;
        if (n == 0) n = 1;
        return n;
    endfunction

endpackage

// File: rtl/vcve2_vrf_access_unit.sv
// rtl/vcve2_vrf_access_unit.sv - sequences per-beat operand reads and result writes over the data port
module vcve2_vrf_access_unit
    import vcve2_pkg::*;
#(
    parameter int unsigned VLEN       = 128,
    parameter int unsigned PIPE_WIDTH = 32,
    parameter int unsigned NUM_SRC    = 3
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               req_i,
    input  logic [NUM_SRC:0]                   sel_operation_i,
    input  vlmul_e                             lmul_i,
    output logic                               agu_load_o,
    input  logic                               agu_ready_i,
    output logic [NUM_SRC:0]                   agu_next_o,
    output logic                               data_req_o,
    output logic                               data_we_o,
    output logic [3:0]                         data_be_o,
    output logic [31:0]                        data_wdata_o,
    input  logic                               data_gnt_i,
    input  logic                               data_rvalid_i,
    input  logic                               data_err_i,
    input  logic                               data_pmp_err_i,
    input  logic [31:0]                        data_rdata_i,
    output logic [NUM_SRC-1:0][PIPE_WIDTH-1:0] rdata_o,
    output logic                               operand_valid_o,
    input  logic                               exec_done_i,
    input  logic [PIPE_WIDTH-1:0]              wdata_i,
    output logic                               busy_o,
    output logic                               vector_done_o,
    output logic                               vector_err_o
);

    localparam int unsigned CW = $clog2(8 * VLEN / PIPE_WIDTH) + 1;
    localparam int unsigned SW = 2;

    vrf_state_t                         state_q, state_d;
    logic [CW-1:0]                      cnt_q, cnt_d;
    logic [CW-1:0]                      nbeats_q, nbeats_d;
    logic [SW-1:0]                      slot_q, slot_d;
    logic [PIPE_WIDTH-1:0]              wdata_q;
    logic [NUM_SRC-1:0][PIPE_WIDTH-1:0] rdata_q;
    logic                               zero_done_q, zero_start;
    logic                               first_valid, next_valid;
    logic [SW-1:0]                      first_slot, next_slot;
    logic                               capture, wcapture, beat_end, bus_err;

    assign bus_err = data_err_i | data_pmp_err_i;

    // lowest selected source, and the next selected source above the current slot
    always_comb begin
        first_valid = 1'b0;
        first_slot  = '0;
        next_valid  = 1'b0;
        next_slot   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (sel_operation_i[k]) begin
                first_valid = 1'b1;
                first_slot  = SW'(k);
            end
            if (sel_operation_i[k] && (SW'(k) > slot_q)) begin
                next_valid = 1'b1;
                next_slot  = SW'(k);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        nbeats_d      = nbeats_q;
        slot_d        = slot_q;
        agu_load_o    = 1'b0;
        agu_next_o    = '0;
        vector_done_o = zero_done_q;
        vector_err_o  = 1'b0;
        zero_start    = 1'b0;
        capture       = 1'b0;
        wcapture      = 1'b0;
        beat_end      = 1'b0;
        case (state_q)
            VRF_IDLE: begin
                if (req_i) begin
                    if (|sel_operation_i) begin
                        agu_load_o = 1'b1;
                        nbeats_d   = CW'(num_beats(VLEN, PIPE_WIDTH, lmul_i));
                        cnt_d      = '0;
                        state_d    = VRF_AGU_WAIT;
                    end else begin
                        zero_start = 1'b1;
                    end
                end
            end
            VRF_AGU_WAIT: begin
                if (agu_ready_i) begin
                    slot_d  = first_slot;
                    state_d = first_valid ? VRF_RD_REQ : VRF_EXEC;
                end
            end
            VRF_RD_REQ: begin
                if (data_gnt_i) begin
                    agu_next_o = (NUM_SRC + 1)'(1) << slot_q;
                    state_d    = VRF_RD_WAIT;
                end
            end
            VRF_RD_WAIT: begin
                if (data_rvalid_i) begin
                    if (bus_err) begin
                        vector_done_o = 1'b1;
                        vector_err_o  = 1'b1;
                        state_d       = VRF_IDLE;
                    end else begin
                        capture = 1'b1;
                        slot_d  = next_slot;
                        state_d = next_valid ? VRF_RD_REQ : VRF_EXEC;
                    end
                end
            end
            VRF_EXEC: begin
                if (exec_done_i) begin
                    wcapture = 1'b1;
                    if (sel_operation_i[NUM_SRC]) state_d = VRF_WR_REQ;
                    else                          beat_end = 1'b1;
                end
            end
            VRF_WR_REQ: begin
                if (data_gnt_i) begin
                    agu_next_o[NUM_SRC] = 1'b1;
                    state_d             = VRF_WR_WAIT;
                end
            end
            VRF_WR_WAIT: begin
                if (data_rvalid_i) begin
                    if (bus_err) begin
                        vector_done_o = 1'b1;
                        vector_err_o  = 1'b1;
                        state_d       = VRF_IDLE;
                    end else begin
                        beat_end = 1'b1;
                    end
                end
            end
            default: state_d = VRF_IDLE;
        endcase

        if (beat_end) begin
            if (cnt_q == nbeats_q - CW'(1)) begin
                vector_done_o = 1'b1;
                state_d       = VRF_IDLE;
            end else begin
                cnt_d   = cnt_q + CW'(1);
                slot_d  = first_slot;
                state_d = first_valid ? VRF_RD_REQ : VRF_EXEC;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= VRF_IDLE;
            cnt_q       <= '0;
            nbeats_q    <= '0;
            slot_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nbeats_q    <= nbeats_d;
            slot_q      <= slot_d;
            zero_done_q <= zero_start;
            if (wcapture) wdata_q <= wdata_i;
            if (capture)  rdata_q[slot_q] <= PIPE_WIDTH'(data_rdata_i);
        end
    end

    assign data_req_o      = (state_q == VRF_RD_REQ) || (state_q == VRF_WR_REQ);
    assign data_we_o       = (state_q == VRF_WR_REQ);
    assign data_be_o       = 4'b1111;
    assign data_wdata_o    = 32'(wdata_q);
    assign rdata_o         = rdata_q;
    assign operand_valid_o = (state_q == VRF_EXEC);
    assign busy_o          = (state_q != VRF_IDLE);

endmodule

// File: tb/tb_vcve2_vrf_access_unit.sv
// tb/tb_vcve2_vrf_access_unit.sv - randomized self-checking bench for the VRF access unit
module tb_vcve2_vrf_access_unit;

    localparam int VLEN = 128;
    localparam int PW   = 32;
    localparam int NS   = 3;
    localparam int EXEC = 9;

    logic                       clk = 1'b0;
    logic                       rst_ni;
    logic                       req_i;
    logic [NS:0]                sel_operation_i;
    vcve2_pkg::vlmul_e          lmul_i;
    logic                       agu_load_o;
    logic                       agu_ready_i;
    logic [NS:0]                agu_next_o;
    logic                       data_req_o, data_we_o;
    logic [3:0]                 data_be_o;
    logic [31:0]                data_wdata_o;
    logic                       data_gnt_i, data_rvalid_i, data_err_i, data_pmp_err_i;
    logic [31:0]                data_rdata_i;
    logic [NS-1:0][PW-1:0]      rdata_o;
    logic                       operand_valid_o;
    logic                       exec_done_i;
    logic [PW-1:0]              wdata_i;
    logic                       busy_o, vector_done_o, vector_err_o;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] model_rd [NS];

    always #5 clk = ~clk;

    vcve2_vrf_access_unit #(.VLEN(VLEN), .PIPE_WIDTH(PW), .NUM_SRC(NS)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .sel_operation_i(sel_operation_i),
        .lmul_i(lmul_i), .agu_load_o(agu_load_o), .agu_ready_i(agu_ready_i),
        .agu_next_o(agu_next_o), .data_req_o(data_req_o), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_gnt_i(data_gnt_i),
        .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i), .data_pmp_err_i(data_pmp_err_i),
        .data_rdata_i(data_rdata_i), .rdata_o(rdata_o), .operand_valid_o(operand_valid_o),
        .exec_done_i(exec_done_i), .wdata_i(wdata_i), .busy_o(busy_o),
        .vector_done_o(vector_done_o), .vector_err_o(vector_err_o)
    );

    function automatic int beats_for(int lmul);
        int n;
        n = (lmul >= 0) ? ((VLEN / PW) * (1 << lmul)) : ((VLEN / PW) / (1 << (-lmul)));
        return (n < 1) ? 1 : n;
    endfunction

    function automatic int ops_per_beat(logic [NS:0] sel);
        int c = 0;
        for (int k = 0; k <= NS; k++) c += sel[k];
        return c;
    endfunction

    task automatic idle_inputs();
        req_i = 0; agu_ready_i = 0; data_gnt_i = 0; data_rvalid_i = 0;
        data_err_i = 0; data_pmp_err_i = 0; exec_done_i = 0; data_rdata_i = 0;
    endtask

    // Plays AGU, memory and pipeline for one instruction; expected order comes from a flat op list.
    task automatic run_instr(input logic [NS:0] sel, input int lmul, input int stall_op,
                             input int stall_cyc, input int err_op, input bit use_pmp,
                             input bit rnd, input bit rst_in_wr,
                             output int grants, output int dones, output int errs,
                             output int stall_req);
        int q[$];
        int n, bus_idx, cur, cur_idx, rv_wait, stall_left, exec_wait, req_run, cyc;
        bit pend, agu_seen, finished, exec_chk, ev_done, ev_err, gnt_now, exp_ov, did_rst;
        logic [31:0] wd_exp;
        logic [NS:0] exp_nx;
        grants = 0; dones = 0; errs = 0; stall_req = 0;
        n = beats_for(lmul);
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k < NS; k++) if (sel[k]) q.push_back(k);
            q.push_back(EXEC);
            if (sel[NS]) q.push_back(NS);
        end
        bus_idx = 0; cur = 0; cur_idx = 0; pend = 0; agu_seen = 0; finished = 0; rv_wait = 0;
        stall_left = stall_cyc; exec_wait = 0; req_run = 0; cyc = 0; exec_chk = 0;
        wd_exp = 0; ev_err = 0; did_rst = 0;

        @(negedge clk);
        idle_inputs();
        req_i = 1; sel_operation_i = sel; lmul_i = vcve2_pkg::vlmul_e'(3'(lmul));
        #1;
        n_cmp++;
        if (agu_load_o !== 1'b1) begin
            n_fail++; $display("FAIL agu_load: got %b want 1", agu_load_o);
        end
        @(posedge clk);

        while (!finished && cyc < 3000) begin
            @(negedge clk);
            idle_inputs();
            if (rnd) req_i = 1'($urandom_range(0, 1));
            agu_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ev_done = 0; ev_err = 0; gnt_now = 0;
            exp_ov = agu_seen && !pend && q.size() > 0 && q[0] == EXEC;
            n_cmp++;
            if (operand_valid_o !== exp_ov) begin
                n_fail++; $display("FAIL operand_valid cyc %0d: got %b want %b", cyc, operand_valid_o, exp_ov);
            end
            if (pend) begin
                if (rv_wait > 0) rv_wait--;
                else if (rst_in_wr && cur == NS) begin
                    rst_ni = 0;
                    #1;
                    n_cmp++;
                    if ({agu_load_o, agu_next_o, data_req_o, data_we_o, data_wdata_o, rdata_o,
                         operand_valid_o, busy_o, vector_done_o, vector_err_o} !== '0) begin
                        n_fail++;
                        $display("FAIL reset_mid: busy=%b req=%b we=%b wd=%h rd=%h", busy_o,
                                 data_req_o, data_we_o, data_wdata_o, rdata_o);
                    end
                    for (int k = 0; k < NS; k++) model_rd[k] = 0;
                    @(posedge clk);
                    @(negedge clk);
                    rst_ni = 1;
                    did_rst = 1; finished = 1; pend = 0;
                end else begin
                    data_rvalid_i = 1;
                    data_rdata_i  = $urandom;
                    if (cur_idx == err_op) begin
                        if (use_pmp) data_pmp_err_i = 1; else data_err_i = 1;
                        ev_err = 1; ev_done = 1;
                    end else begin
                        if (cur < NS) model_rd[cur] = data_rdata_i;
                        if (q.size() == 0) ev_done = 1;
                    end
                    pend = 0;
                end
            end else if (data_req_o) begin
                req_run++;
                if (bus_idx == stall_op && stall_left > 0) stall_left--;
                else if (!(rnd && $urandom_range(0, 2) == 0)) begin
                    data_gnt_i = 1; gnt_now = 1; grants++;
                    n_cmp++;
                    if (q.size() == 0 || q[0] == EXEC || !agu_seen) begin
                        n_fail++; $display("FAIL unexpected_req: beat op list front=%0d", (q.size() > 0) ? q[0] : -1);
                        cur = 0;
                    end else begin
                        cur = q.pop_front();
                    end
                    n_cmp++;
                    if (data_we_o !== (cur == NS)) begin
                        n_fail++; $display("FAIL data_we: got %b want %b", data_we_o, cur == NS);
                    end
                    if (bus_idx == stall_op) stall_req = req_run;
                    cur_idx = bus_idx; bus_idx++; req_run = 0; pend = 1;
                    rv_wait = rnd ? $urandom_range(0, 2) : 0;
                end
            end else if (exp_ov && operand_valid_o) begin
                if (!exec_chk) begin
                    exec_chk = 1;
                    for (int k = 0; k < NS; k++) if (sel[k]) begin
                        n_cmp++;
                        if (rdata_o[k] !== model_rd[k]) begin
                            n_fail++; $display("FAIL operand%0d: got %h want %h", k, rdata_o[k], model_rd[k]);
                        end
                    end
                    exec_wait = rnd ? $urandom_range(0, 3) : 0;
                end
                if (exec_wait > 0) exec_wait--;
                else begin
                    exec_done_i = 1; wdata_i = $urandom; wd_exp = wdata_i;
                    void'(q.pop_front());
                    exec_chk = 0;
                    if (q.size() == 0) ev_done = 1;
                end
            end
            if (!did_rst) begin
                #1;
                exp_nx = gnt_now ? ((NS + 1)'(1) << cur) : '0;
                n_cmp++;
                if (agu_next_o !== exp_nx) begin
                    n_fail++; $display("FAIL agu_next: got %b want %b", agu_next_o, exp_nx);
                end
                if (gnt_now && cur == NS) begin
                    n_cmp++;
                    if (data_wdata_o !== wd_exp || data_be_o !== 4'hf) begin
                        n_fail++; $display("FAIL wdata: got %h/%h want %h/f", data_wdata_o, data_be_o, wd_exp);
                    end
                end
                n_cmp++;
                if (vector_done_o !== ev_done || vector_err_o !== ev_err) begin
                    n_fail++;
                    $display("FAIL done_err cyc %0d: got %b%b want %b%b", cyc, vector_done_o, vector_err_o, ev_done, ev_err);
                end
                dones += int'(vector_done_o);
                errs  += int'(vector_err_o);
                if (ev_done) finished = 1;
                @(posedge clk);
                if (agu_ready_i) agu_seen = 1;
            end
            cyc++;
        end
        if (!finished) begin
            n_cmp++; n_fail++;
            $display("FAIL timeout: instruction did not finish, ops left %0d", q.size());
        end else if (!did_rst) begin
            @(negedge clk);
            idle_inputs();
            #1;
            n_cmp++;
            if (busy_o !== 1'b0) begin
                n_fail++; $display("FAIL busy_after_done: got %b want 0", busy_o);
            end
            if (ev_err) begin
                for (int k = 0; k < NS; k++) begin
                    n_cmp++;
                    if (rdata_o[k] !== model_rd[k]) begin
                        n_fail++; $display("FAIL err_keeps_operand%0d: got %h want %h", k, rdata_o[k], model_rd[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        sel_operation_i = '0; lmul_i = vcve2_pkg::LMUL_1; wdata_i = '0; rst_ni = 0;
        for (int k = 0; k < NS; k++) model_rd[k] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({agu_load_o, agu_next_o, data_req_o, data_we_o, data_wdata_o, rdata_o,
             operand_valid_o, busy_o, vector_done_o, vector_err_o} !== '0) begin
            n_fail++; $display("FAIL reset_state: busy=%b req=%b rd=%h", busy_o, data_req_o, rdata_o);
        end
        rst_ni = 1;
    endtask

    task automatic test_basic();
        int g, d, e, s;
        run_instr(4'b1011, 0, -1, 0, -1, 0, 0, 0, g, d, e, s);
        n_cmp++;
        if (g != 12 || d != 1 || e != 0) begin
            n_fail++; $display("FAIL basic: grants %0d done %0d err %0d want 12 1 0", g, d, e);
        end
    endtask

    task automatic test_lmul_min();
        int g, d, e, s;
        logic [NS:0] sel;
        sel = 4'($urandom_range(1, 15));
        run_instr(sel, -3, -1, 0, -1, 0, 0, 0, g, d, e, s);
        n_cmp++;
        if (g != ops_per_beat(sel) || d != 1) begin
            n_fail++; $display("FAIL lmul_min: grants %0d done %0d want %0d 1", g, d, ops_per_beat(sel));
        end
    endtask

    task automatic test_write_only();
        int g, d, e, s;
        run_instr(4'b1000, 3, -1, 0, -1, 0, 0, 0, g, d, e, s);
        n_cmp++;
        if (g != 32 || d != 1) begin
            n_fail++; $display("FAIL write_only: grants %0d done %0d want 32 1", g, d);
        end
    endtask

    task automatic test_stall();
        int g, d, e, s;
        run_instr(4'b1011, 0, 1, 3, -1, 0, 0, 0, g, d, e, s);
        n_cmp++;
        if (s != 4 || g != 12 || d != 1) begin
            n_fail++; $display("FAIL stall: req cycles %0d grants %0d done %0d want 4 12 1", s, g, d);
        end
    endtask

    task automatic test_error();
        int g, d, e, s;
        run_instr(4'b1011, 0, -1, 0, 4, 0, 0, 0, g, d, e, s);
        n_cmp++;
        if (g != 5 || d != 1 || e != 1) begin
            n_fail++; $display("FAIL error: grants %0d done %0d err %0d want 5 1 1", g, d, e);
        end
        run_instr(4'b1111, 1, -1, 0, 7, 1, 1, 0, g, d, e, s);
        n_cmp++;
        if (g != 8 || d != 1 || e != 1) begin
            n_fail++; $display("FAIL pmp_error: grants %0d done %0d err %0d want 8 1 1", g, d, e);
        end
    endtask

    task automatic test_zero_sel();
        @(negedge clk);
        idle_inputs();
        req_i = 1; sel_operation_i = '0; lmul_i = vcve2_pkg::LMUL_2;
        #1;
        n_cmp++;
        if (agu_load_o !== 0 || vector_done_o !== 0) begin
            n_fail++; $display("FAIL zero_sel_start: load %b done %b want 0 0", agu_load_o, vector_done_o);
        end
        @(negedge clk);
        req_i = 0;
        #1;
        n_cmp++;
        if (vector_done_o !== 1 || busy_o !== 0 || data_req_o !== 0) begin
            n_fail++; $display("FAIL zero_sel_done: done %b busy %b req %b want 1 0 0", vector_done_o, busy_o, data_req_o);
        end
        @(negedge clk);
        n_cmp++;
        if (vector_done_o !== 0 || data_req_o !== 0) begin
            n_fail++; $display("FAIL zero_sel_after: done %b req %b want 0 0", vector_done_o, data_req_o);
        end
    endtask

    task automatic test_reset_mid();
        int g, d, e, s;
        run_instr(4'b1001, 1, -1, 0, -1, 0, 0, 1, g, d, e, s);
        n_cmp++;
        if (d != 0 || g != 2) begin
            n_fail++; $display("FAIL reset_mid_run: done %0d grants %0d want 0 2", d, g);
        end
        run_instr(4'b1111, 1, -1, 0, -1, 0, 0, 0, g, d, e, s);
        n_cmp++;
        if (g != 32 || d != 1) begin
            n_fail++; $display("FAIL after_reset: grants %0d done %0d want 32 1", g, d);
        end
    endtask

    task automatic test_back_to_back();
        int g, d, e, s, lm, want;
        logic [NS:0] sel;
        for (int i = 0; i < 8; i++) begin
            sel  = 4'($urandom_range(1, 15));
            lm   = $urandom_range(0, 6) - 3;
            want = beats_for(lm) * ops_per_beat(sel);
            run_instr(sel, lm, -1, 0, -1, 0, 1, 0, g, d, e, s);
            n_cmp++;
            if (g != want || d != 1 || e != 0) begin
                n_fail++;
                $display("FAIL random%0d sel %b lmul %0d: grants %0d done %0d err %0d want %0d 1 0", i, sel, lm, g, d, e, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lmul_min();
        test_write_only();
        test_stall();
        test_error();
        test_zero_sel();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
